// File: rtl/id_pkg.sv
// Shared ID-stage definitions: ALU op codes, operand selects, opcodes and the decoded bundle.
// MUL/DIV/REM codes are only produced when ID_RVM_EN is defined.
package id_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_ADDW   = 5'd10;
    localparam logic [4:0] ALU_SUBW   = 5'd11;
    localparam logic [4:0] ALU_SLLW   = 5'd12;
    localparam logic [4:0] ALU_SRLW   = 5'd13;
    localparam logic [4:0] ALU_SRAW   = 5'd14;
    localparam logic [4:0] ALU_EQ     = 5'd15;
    localparam logic [4:0] ALU_NE     = 5'd16;
    localparam logic [4:0] ALU_GE     = 5'd17;
    localparam logic [4:0] ALU_GEU    = 5'd18;
    localparam logic [4:0] ALU_MUL    = 5'd19;  // 19..26 follow funct3 order mul..remu
    localparam logic [4:0] ALU_MULW   = 5'd27;
    localparam logic [4:0] ALU_DIVW   = 5'd28;
    localparam logic [4:0] ALU_DIVUW  = 5'd29;
    localparam logic [4:0] ALU_REMW   = 5'd30;
    localparam logic [4:0] ALU_NONE   = 5'd31;

    localparam logic [2:0] SRC1_RS1   = 3'd0;
    localparam logic [2:0] SRC1_ZERO  = 3'd4;
    localparam logic [2:0] SRC1_PC    = 3'd5;
    localparam logic [2:0] SRC2_RS2   = 3'd0;
    localparam logic [2:0] SRC2_IMM   = 3'd1;
    localparam logic [2:0] SRC2_FOUR  = 3'd5;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_IMM32   = 7'b0011011;
    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_REG32   = 7'b0111011;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [4:0]  alu_ctrl;
        logic [2:0]  src1_sel;
        logic [2:0]  src2_sel;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        reg_w_en;
        logic        branch;
        logic        jalr;
        logic        illegal;
    } dec_bundle_t;

    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_decode_queue_if.sv
// IF/EX-facing bus of the decode queue. Handshake: a beat moves on a rising edge where
// valid & ready are both high; valid never waits on ready, and ready never depends on valid.
interface id_decode_queue_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_ins;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_ins;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_alu_ctrl;
    logic [2:0]      out_src1_sel;
    logic [2:0]      out_src2_sel;
    logic            out_mem_r_en;
    logic            out_mem_w_en;
    logic            out_reg_w_en;
    logic            out_branch;
    logic            out_jalr;
    logic            out_illegal;

    modport master (
        output in_valid, in_pc, in_ins, flush, out_ready,
        input  in_ready, redirect_valid, redirect_pc, out_valid, out_pc, out_ins,
               out_rs1, out_rs2, out_rd, out_imm, out_alu_ctrl, out_src1_sel, out_src2_sel,
               out_mem_r_en, out_mem_w_en, out_reg_w_en, out_branch, out_jalr, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_ins, flush, out_ready,
        output in_ready, redirect_valid, redirect_pc, out_valid, out_pc, out_ins,
               out_rs1, out_rs2, out_rd, out_imm, out_alu_ctrl, out_src1_sel, out_src2_sel,
               out_mem_r_en, out_mem_w_en, out_reg_w_en, out_branch, out_jalr, out_illegal
    );
endinterface

// File: rtl/id_decoder.sv
// Pure combinational RV64I instruction decoder producing a dec_bundle_t.
// ID_RVM_EN adds the M-extension encodings; otherwise they decode as illegal.
module id_decoder
    import id_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] ins,
    output dec_bundle_t dec
);

    logic        rv64;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        ill;
    dec_bundle_t d;

    assign rv64   = (XLEN == 64);
    assign opcode = ins[6:0];
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];
    assign imm_i  = {{52{ins[31]}}, ins[31:20]};
    assign imm_s  = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {{32{ins[31]}}, ins[31:12], 12'b0};
    assign imm_j  = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        d          = '0;
        ill        = 1'b0;
        d.rs1      = ins[19:15];
        d.rs2      = ins[24:20];
        d.rd       = ins[11:7];
        d.alu_ctrl = ALU_ADD;
        case (opcode)
            OP_LUI: begin
                d.imm = imm_u; d.src1_sel = SRC1_ZERO; d.src2_sel = SRC2_IMM; d.reg_w_en = 1'b1;
            end
            OP_AUIPC: begin
                d.imm = imm_u; d.src1_sel = SRC1_PC; d.src2_sel = SRC2_IMM; d.reg_w_en = 1'b1;
            end
            OP_JAL: begin
                d.imm = imm_j; d.src1_sel = SRC1_PC; d.src2_sel = SRC2_FOUR; d.reg_w_en = 1'b1;
            end
            OP_JALR: begin
                // ALU produces the link value; EX forms the target from rs1 + imm.
                d.imm = imm_i; d.src1_sel = SRC1_PC; d.src2_sel = SRC2_FOUR;
                d.reg_w_en = 1'b1; d.jalr = 1'b1;
                ill = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                d.imm = imm_b; d.branch = 1'b1;
                case (f3)
                    3'b000:  d.alu_ctrl = ALU_EQ;
                    3'b001:  d.alu_ctrl = ALU_NE;
                    3'b100:  d.alu_ctrl = ALU_SLT;
                    3'b101:  d.alu_ctrl = ALU_GE;
                    3'b110:  d.alu_ctrl = ALU_SLTU;
                    3'b111:  d.alu_ctrl = ALU_GEU;
                    default: ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                d.imm = imm_i; d.src2_sel = SRC2_IMM; d.mem_r_en = 1'b1; d.reg_w_en = 1'b1;
                ill = (f3 == 3'b111) || (!rv64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OP_STORE: begin
                d.imm = imm_s; d.src2_sel = SRC2_IMM; d.mem_w_en = 1'b1;
                ill = f3[2] || (!rv64 && f3 == 3'b011);
            end
            OP_IMM: begin
                d.imm = imm_i; d.src2_sel = SRC2_IMM; d.reg_w_en = 1'b1;
                d.alu_ctrl = base_alu(f3, (f3 == 3'b101) && ins[30]);
                if (f3 == 3'b001)
                    ill = (ins[31:26] != 6'b0) || (!rv64 && ins[25]);
                else if (f3 == 3'b101)
                    ill = ({ins[31], ins[29:26]} != 5'b0) || (!rv64 && ins[25]);
            end
            OP_REG: begin
                d.reg_w_en = 1'b1;
                if (f7 == 7'b0000000)
                    d.alu_ctrl = base_alu(f3, 1'b0);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    d.alu_ctrl = base_alu(f3, 1'b1);
`ifdef ID_RVM_EN
                else if (f7 == 7'b0000001)
                    d.alu_ctrl = ALU_MUL + {2'b00, f3};
`endif
                else
                    ill = 1'b1;
            end
            OP_IMM32: begin
                d.imm = imm_i; d.src2_sel = SRC2_IMM; d.reg_w_en = 1'b1;
                ill = !rv64;
                case (f3)
                    3'b000:  d.alu_ctrl = ALU_ADDW;
                    3'b001:  if (f7 == 7'b0000000) d.alu_ctrl = ALU_SLLW; else ill = 1'b1;
                    3'b101: begin
                        if (f7 == 7'b0000000)      d.alu_ctrl = ALU_SRLW;
                        else if (f7 == 7'b0100000) d.alu_ctrl = ALU_SRAW;
                        else                       ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_REG32: begin
                d.reg_w_en = 1'b1;
                ill = !rv64;
                case ({f7, f3})
                    {7'b0000000, 3'b000}: d.alu_ctrl = ALU_ADDW;
                    {7'b0100000, 3'b000}: d.alu_ctrl = ALU_SUBW;
                    {7'b0000000, 3'b001}: d.alu_ctrl = ALU_SLLW;
                    {7'b0000000, 3'b101}: d.alu_ctrl = ALU_SRLW;
                    {7'b0100000, 3'b101}: d.alu_ctrl = ALU_SRAW;
`ifdef ID_RVM_EN
                    // remuw has no code of its own and stays illegal.
                    {7'b0000001, 3'b000}: d.alu_ctrl = ALU_MULW;
                    {7'b0000001, 3'b100}: d.alu_ctrl = ALU_DIVW;
                    {7'b0000001, 3'b101}: d.alu_ctrl = ALU_DIVUW;
                    {7'b0000001, 3'b110}: d.alu_ctrl = ALU_REMW;
`endif
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        if (ill) begin
            d          = '0;
            d.rs1      = ins[19:15];
            d.rs2      = ins[24:20];
            d.rd       = ins[11:7];
            d.alu_ctrl = ALU_NONE;
            d.illegal  = 1'b1;
        end
        dec = d;
    end

endmodule

// File: rtl/id_decode_queue.sv
// Decode stage: decodes accepted instructions into a DEPTH-entry FIFO and redirects IF on JAL.
// Build with ID_RVM_EN defined to accept the M-extension (see id_decoder).
module id_decode_queue
    import id_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    id_decode_queue_if.slave  bus
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    dec_bundle_t     dec_in;
    dec_bundle_t     dec_mem [DEPTH];
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [31:0]     ins_mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [PW:0]     count;
    logic            push, pop, is_jal;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    dec_bundle_t     head;

    id_decoder #(.XLEN(XLEN)) u_decoder (.ins(bus.in_ins), .dec(dec_in));

    assign bus.in_ready  = ~reset & (count != FULL_CNT);
    assign bus.out_valid = (count != '0);
    assign is_jal        = (bus.in_ins[6:0] == OP_JAL);
    // The cycle after a JAL is a wrong-path fetch; it is dropped without lowering in_ready.
    assign push          = bus.in_valid & bus.in_ready & ~bus.flush & ~redirect_q;
    assign pop           = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dec_mem[i] <= '0;
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            redirect_q <= 1'b0;
        end else begin
            if (push) begin
                dec_mem[wr_ptr] <= dec_in;
                pc_mem[wr_ptr]  <= bus.in_pc;
                ins_mem[wr_ptr] <= bus.in_ins;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            redirect_q <= push & is_jal;
            if (push & is_jal)
                redirect_pc_q <= bus.in_pc + dec_in.imm[XLEN-1:0];
        end
    end

    assign head               = dec_mem[rd_ptr];
    assign bus.redirect_valid = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.out_pc         = pc_mem[rd_ptr];
    assign bus.out_ins        = ins_mem[rd_ptr];
    assign bus.out_rs1        = head.rs1;
    assign bus.out_rs2        = head.rs2;
    assign bus.out_rd         = head.rd;
    assign bus.out_imm        = head.imm[XLEN-1:0];
    assign bus.out_alu_ctrl   = head.alu_ctrl;
    assign bus.out_src1_sel   = head.src1_sel;
    assign bus.out_src2_sel   = head.src2_sel;
    assign bus.out_mem_r_en   = head.mem_r_en;
    assign bus.out_mem_w_en   = head.mem_w_en;
    assign bus.out_reg_w_en   = head.reg_w_en;
    assign bus.out_branch     = head.branch;
    assign bus.out_jalr       = head.jalr;
    assign bus.out_illegal    = head.illegal;

endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: decode vector table, hand-written queue corner cases,
// and a randomized run against a queue-level reference model.
module tb_id_decode_queue;
    import id_pkg::*;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    localparam logic [5:0] F_MR = 6'b100000;
    localparam logic [5:0] F_MW = 6'b010000;
    localparam logic [5:0] F_RW = 6'b001000;
    localparam logic [5:0] F_BR = 6'b000100;
    localparam logic [5:0] F_JR = 6'b000010;
    localparam logic [5:0] F_IL = 6'b000001;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] JAL8 = 32'h0080_006F;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm;
        logic [4:0]  alu;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [5:0]  fl;   // {mem_r, mem_w, reg_w, branch, jalr, illegal}
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    id_decode_queue_if #(.XLEN(XLEN)) bus ();
    id_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic [63:0] imm, input logic [4:0] alu,
                                input logic [2:0] s1, input logic [2:0] s2, input logic [5:0] fl);
        vec_t v;
        v.ins = ins; v.imm = imm; v.alu = alu; v.s1 = s1; v.s2 = s2; v.fl = fl;
        return v;
    endfunction

    function automatic logic [16:0] dut_ctrl();
        return {bus.out_alu_ctrl, bus.out_src1_sel, bus.out_src2_sel, bus.out_mem_r_en,
                bus.out_mem_w_en, bus.out_reg_w_en, bus.out_branch, bus.out_jalr, bus.out_illegal};
    endfunction

    task automatic check_head(input string name, input vec_t v, input logic [63:0] pc);
        logic [31:0] ins;
        ins = v.ins;
        check({name, "_pc"},   bus.out_pc, pc);
        check({name, "_ins"},  bus.out_ins, ins);
        check({name, "_regs"}, {bus.out_rs1, bus.out_rs2, bus.out_rd}, {ins[19:15], ins[24:20], ins[11:7]});
        check({name, "_imm"},  bus.out_imm, v.imm);
        check({name, "_ctrl"}, dut_ctrl(), {v.alu, v.s1, v.s2, v.fl});
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_ins   = ins;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0);
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] base, pc;
        int          idx_q[$];
        logic [63:0] pc_q[$];
        logic        m_rv, v, ordy, fl, m_push, m_pop;
        logic [63:0] m_rpc;
        int          k;

        vecs.push_back(mk(32'h0050_0093, 64'd5, ALU_ADD, SRC1_RS1, SRC2_IMM, F_RW));
        vecs.push_back(mk(32'h0020_81B3, 64'd0, ALU_ADD, SRC1_RS1, SRC2_RS2, F_RW));
        vecs.push_back(mk(32'h4020_81B3, 64'd0, ALU_SUB, SRC1_RS1, SRC2_RS2, F_RW));
        vecs.push_back(mk(32'h1234_52B7, 64'h1234_5000, ALU_ADD, SRC1_ZERO, SRC2_IMM, F_RW));
        vecs.push_back(mk(32'hFFFF_F317, 64'hFFFF_FFFF_FFFF_F000, ALU_ADD, SRC1_PC, SRC2_IMM, F_RW));
        vecs.push_back(mk(32'hFF81_3383, -64'sd8, ALU_ADD, SRC1_RS1, SRC2_IMM, F_MR | F_RW));
        vecs.push_back(mk(32'h0071_3823, 64'd16, ALU_ADD, SRC1_RS1, SRC2_IMM, F_MW));
        vecs.push_back(mk(32'hFE20_8EE3, -64'sd4, ALU_EQ, SRC1_RS1, SRC2_RS2, F_BR));
        vecs.push_back(mk(32'h0020_6463, 64'd8, ALU_SLTU, SRC1_RS1, SRC2_RS2, F_BR));
        vecs.push_back(mk(JAL8, 64'd8, ALU_ADD, SRC1_PC, SRC2_FOUR, F_RW));
        vecs.push_back(mk(32'h0002_80E7, 64'd0, ALU_ADD, SRC1_PC, SRC2_FOUR, F_RW | F_JR));
        vecs.push_back(mk(32'h43F2_5213, 64'h43F, ALU_SRA, SRC1_RS1, SRC2_IMM, F_RW));
        vecs.push_back(mk(32'h0073_02BB, 64'd0, ALU_ADDW, SRC1_RS1, SRC2_RS2, F_RW));
        vecs.push_back(mk(32'h4030_D09B, 64'h403, ALU_SRAW, SRC1_RS1, SRC2_IMM, F_RW));
        vecs.push_back(mk(32'hFFF0_C113, -64'sd1, ALU_XOR, SRC1_RS1, SRC2_IMM, F_RW));
`ifdef ID_RVM_EN
        vecs.push_back(mk(32'h0220_8033, 64'd0, 5'd19, SRC1_RS1, SRC2_RS2, F_RW));
`else
        vecs.push_back(mk(32'h0220_8033, 64'd0, 5'd31, 3'd0, 3'd0, F_IL));
`endif
        vecs.push_back(mk(32'hFFFF_FFFF, 64'd0, 5'd31, 3'd0, 3'd0, F_IL));
        vecs.push_back(mk(32'h4020_91B3, 64'd0, 5'd31, 3'd0, 3'd0, F_IL));
        vecs.push_back(mk(32'h0000_F003, 64'd0, 5'd31, 3'd0, 3'd0, F_IL));

        // Reset state
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_redirect", {bus.redirect_valid, bus.redirect_pc}, 0);
        check("rst_bundle", {bus.out_imm, dut_ctrl()}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        // Decode table, one instruction at a time
        foreach (vecs[i]) begin
            pc = 64'h8000_0000 + 64'(4 * i);
            drive(1'b1, pc, vecs[i].ins);
            @(negedge clk);
            drive(1'b0, '0, '0);
            check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            check_head($sformatf("vec%0d", i), vecs[i], pc);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check($sformatf("vec%0d_drained", i), bus.out_valid, 0);
        end

        // Fill to DEPTH, hold a fifth, pop frees a slot only on the next cycle
        base = 64'h8000_0100;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, base + 64'(4 * i), vecs[i].ins);
            @(negedge clk);
        end
        drive(1'b1, base + 64'(4 * DEPTH), vecs[DEPTH].ins);
        check("full_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("full_held_ready", bus.in_ready, 0);
        check("full_head", bus.out_pc, base);
        bus.out_ready = 1'b1;
        #1;
        check("full_no_passthru", bus.in_ready, 0);
        @(negedge clk);
        check("pop_frees", bus.in_ready, 1);
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, '0, '0);
        check("refull_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        for (int j = 1; j <= DEPTH; j++) begin
            check($sformatf("drain%0d", j), {bus.out_valid, bus.out_pc}, {1'b1, base + 64'(4 * j)});
            @(negedge clk);
        end
        check("drain_empty", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // Flush with three queued and a same-cycle push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, base + 64'(4 * i), ADDI);
            @(negedge clk);
        end
        bus.flush = 1'b1;
        drive(1'b1, 64'h9000_0000, ADDI);
        @(negedge clk);
        bus.flush = 1'b0;
        drive(1'b0, '0, '0);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_in_ready", bus.in_ready, 1);
        drive(1'b1, 64'h9000_0040, ADDI);
        @(negedge clk);
        drive(1'b0, '0, '0);
        check("post_flush_head", {bus.out_valid, bus.out_pc}, {1'b1, 64'h9000_0040});
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_flush_empty", bus.out_valid, 0);

        // JAL redirect and wrong-path bubble
        drive(1'b1, 64'h8000_0010, JAL8);
        @(negedge clk);
        drive(1'b1, 64'h8000_0014, ADDI);
        check("jal_redirect", {bus.redirect_valid, bus.redirect_pc}, {1'b1, 64'h8000_0018});
        check("jal_ready_kept", bus.in_ready, 1);
        @(negedge clk);
        drive(1'b0, '0, '0);
        check("jal_pulse_end", bus.redirect_valid, 0);
        check_head("jal_head", vecs[9], 64'h8000_0010);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("jal_bubble_dropped", bus.out_valid, 0);

        // Flush beats JAL
        bus.flush = 1'b1;
        drive(1'b1, 64'h8000_0020, JAL8);
        @(negedge clk);
        bus.flush = 1'b0;
        drive(1'b0, '0, '0);
        check("flush_over_jal", {bus.redirect_valid, bus.out_valid}, 0);

        // Reset mid-operation with a pending redirect
        drive(1'b1, 64'h8000_0030, ADDI);
        @(negedge clk);
        drive(1'b1, 64'h8000_0034, JAL8);
        @(negedge clk);
        drive(1'b0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cleared", {bus.out_valid, bus.redirect_valid, bus.in_ready}, 0);
        reset = 1'b0;

        // Continuous push+pop across pointer wrap
        base = 64'h8000_0200;
        drive(1'b1, base, ADDI);
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 2 * DEPTH + 1; j++) begin
            check($sformatf("stream%0d", j), {bus.out_valid, bus.in_ready, bus.out_pc},
                  {2'b11, base + 64'(4 * j)});
            drive(1'b1, base + 64'(4 * (j + 1)), ADDI);
            @(negedge clk);
        end
        drive(1'b0, '0, '0);
        check("stream_last", bus.out_pc, base + 64'(4 * (2 * DEPTH + 1)));
        @(negedge clk);
        check("stream_empty", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // Randomized traffic against a queue-level model
        do_reset();
        m_rv  = 1'b0;
        m_rpc = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            check("rnd_in_ready", bus.in_ready, idx_q.size() != DEPTH);
            check("rnd_out_valid", bus.out_valid, idx_q.size() != 0);
            check("rnd_redirect", bus.redirect_valid, m_rv);
            if (m_rv) check("rnd_redirect_pc", bus.redirect_pc, m_rpc);
            if (idx_q.size() != 0) check_head("rnd_head", vecs[idx_q[0]], pc_q[0]);

            v    = ($urandom_range(0, 3) != 0);
            k    = $urandom_range(0, vecs.size() - 1);
            pc   = {32'h0, $urandom} & ~64'h3;
            ordy = $urandom_range(0, 1) == 1;
            fl   = ($urandom_range(0, 24) == 0);
            drive(v, pc, vecs[k].ins);
            bus.out_ready = ordy;
            bus.flush     = fl;

            m_push = v && (idx_q.size() != DEPTH) && !fl && !m_rv;
            m_pop  = (idx_q.size() != 0) && ordy;
            if (fl) begin
                idx_q.delete();
                pc_q.delete();
                m_rv = 1'b0;
            end else begin
                if (m_pop) begin
                    void'(idx_q.pop_front());
                    void'(pc_q.pop_front());
                end
                if (m_push) begin
                    idx_q.push_back(k);
                    pc_q.push_back(pc);
                end
                m_rv = m_push && (vecs[k].ins[6:0] == 7'b1101111);
                if (m_rv) m_rpc = pc + vecs[k].imm;
            end
        end
        @(negedge clk);
        drive(1'b0, '0, '0);
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
